// File: rtl/xor_fault_bist_sequencer.sv
// Exhaustive stuck-at fault grading sequencer for an NUM_IN-input XOR-reduce gate.
// Define FAULT_DROP_EN to skip a fault pass's remaining patterns after its first detection.
module xor_fault_bist_sequencer #(
    parameter int NUM_IN     = 2,
    parameter int SETTLE_CYC = 1,
    parameter int NUM_FLT    = 2 * (NUM_IN + 1),
    parameter int FID_W      = $clog2(NUM_FLT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [NUM_IN-1:0]  pat_out,
    input  logic               dut_o,
    output logic               fault_en,
    output logic [FID_W-1:0]   fault_id,
    output logic               busy,
    output logic               done,
    output logic               good_err,
    output logic [NUM_FLT-1:0] det_mask,
    output logic [FID_W:0]     det_count
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [FID_W-1:0] LAST_ID     = FID_W'(NUM_FLT - 1);
    localparam logic [FID_W:0]   CNT_MAX     = (FID_W + 1)'(NUM_FLT);

`ifdef FAULT_DROP_EN
    localparam logic DROP = 1'b1;
`else
    localparam logic DROP = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        FIN
    } state_t;

    state_t          state;
    logic [SW-1:0]   settle_cnt;
    logic            mismatch;
    logic            last_pat;
    logic            advance;

    assign mismatch = dut_o ^ (^pat_out);
    assign last_pat = (pat_out == '1);
    assign advance  = last_pat | (DROP & mismatch);

    // fault_en doubles as the pass flag: 0 only during the fault-free pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            pat_out    <= '0;
            fault_en   <= 1'b0;
            fault_id   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            good_err   <= 1'b0;
            det_mask   <= '0;
            det_count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        det_mask  <= '0;
                        det_count <= '0;
                        good_err  <= 1'b0;
                        fault_en  <= 1'b0;
                        fault_id  <= '0;
                        pat_out   <= '0;
                        busy      <= 1'b1;
                        state     <= APPLY;
                    end
                end
                APPLY: begin
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                SAMPLE: begin
                    if (!fault_en) begin
                        if (mismatch) begin
                            good_err <= 1'b1;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            pat_out  <= '0;
                            state    <= FIN;
                        end else if (last_pat) begin
                            fault_en <= 1'b1;
                            fault_id <= '0;
                            pat_out  <= '0;
                            state    <= APPLY;
                        end else begin
                            pat_out <= pat_out + NUM_IN'(1);
                            state   <= APPLY;
                        end
                    end else begin
                        if (mismatch && !det_mask[fault_id]) begin
                            det_mask[fault_id] <= 1'b1;
                            if (det_count != CNT_MAX) begin
                                det_count <= det_count + (FID_W + 1)'(1);
                            end
                        end
                        if (advance) begin
                            pat_out <= '0;
                            if (fault_id == LAST_ID) begin
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                fault_en <= 1'b0;
                                state    <= FIN;
                            end else begin
                                fault_id <= fault_id + FID_W'(1);
                                state    <= APPLY;
                            end
                        end else begin
                            pat_out <= pat_out + NUM_IN'(1);
                            state   <= APPLY;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
